// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the parametrised FIFO slice.
//   fifo_state_e : 3-bit FSM state encodings, also exported on the debug port
//   ptr_width()  : read/write pointer width for a given FIFO depth
package fifo_pkg;

  typedef enum logic [2:0] {
    INIT     = 3'b000,
    WRITE    = 3'b001,
    READ     = 3'b010,
    RDWR     = 3'b011,
    WR_ERROR = 3'b101,
    RD_ERROR = 3'b110,
    NO_OP    = 3'b111
  } fifo_state_e;

  // Clamp to one bit so a degenerate depth still yields a legal vector.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_param_ns.sv
// fifo_param_ns
// Combinational next-state and action decode for fifo_param.
// Inputs:
//   wr_en, rd_en : raw producer/consumer requests (X/Z counts as 0)
//   state        : current FSM state
//   full, empty  : occupancy flags of the current cycle
// Outputs:
//   next_state   : state to load on the next edge
//   do_wr, do_rd : memory write / read strobes for this edge
//   wr_ack, wr_err, rd_ack, rd_err : handshake values to register
module fifo_param_ns
  import fifo_pkg::*;
(
  input  logic        wr_en,
  input  logic        rd_en,
  input  fifo_state_e state,
  input  logic        full,
  input  logic        empty,
  output fifo_state_e next_state,
  output logic        do_wr,
  output logic        do_rd,
  output logic        wr_ack,
  output logic        wr_err,
  output logic        rd_ack,
  output logic        rd_err
);

  logic wr_req;
  logic rd_req;

  // Only a clean 1 counts as a request, so an undriven enable cannot
  // corrupt the pointers.
  assign wr_req = (wr_en === 1'b1);
  assign rd_req = (rd_en === 1'b1);

  always_comb begin
    next_state = state;
    do_wr      = 1'b0;
    do_rd      = 1'b0;
    wr_ack     = 1'b0;
    wr_err     = 1'b0;
    rd_ack     = 1'b0;
    rd_err     = 1'b0;

    unique case ({wr_req, rd_req})
      2'b00: begin
        next_state = (state == INIT) ? INIT : NO_OP;
      end
      2'b10: begin
        if (full) begin
          next_state = WR_ERROR;
          wr_err     = 1'b1;
        end else begin
          next_state = WRITE;
          do_wr      = 1'b1;
          wr_ack     = 1'b1;
        end
      end
      2'b01: begin
        if (empty) begin
          next_state = RD_ERROR;
          rd_err     = 1'b1;
        end else begin
          next_state = READ;
          do_rd      = 1'b1;
          rd_ack     = 1'b1;
        end
      end
      default: begin
        // No write-to-read bypass: on an empty FIFO only the write happens
        // and the read is reported as rejected.
        if (empty) begin
          next_state = WRITE;
          do_wr      = 1'b1;
          wr_ack     = 1'b1;
          rd_err     = 1'b1;
        end else begin
          next_state = RDWR;
          do_wr      = 1'b1;
          do_rd      = 1'b1;
          wr_ack     = 1'b1;
          rd_ack     = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/fifo_param.sv
// fifo_param
// Parametrised single-clock FIFO with registered handshakes and
// almost-full / almost-empty flags.
// Ports:
//   clk, reset_n        : rising-edge clock, asynchronous active-low reset
//   wr_en, d_in         : producer request and write data
//   rd_en, d_out        : consumer request and registered read data
//   full, empty         : occupancy == DEPTH / == 0
//   almost_full/empty   : occupancy >= AF_LEVEL / <= AE_LEVEL
//   wr_ack, wr_err      : write accepted / rejected on the previous edge
//   rd_ack, rd_err      : read performed / rejected on the previous edge
//   data_count          : occupancy 0..DEPTH
//   state               : current FSM state (debug)
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  logic                    rd_en,
  input  logic [DATA_WIDTH-1:0]   d_in,
  output logic [DATA_WIDTH-1:0]   d_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic                    wr_ack,
  output logic                    wr_err,
  output logic                    rd_ack,
  output logic                    rd_err,
  output logic [$clog2(DEPTH):0]  data_count,
  output logic [2:0]              state
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  fifo_state_e           state_q;
  fifo_state_e           next_state;
  logic                  do_wr;
  logic                  do_rd;
  logic                  wr_ack_d;
  logic                  wr_err_d;
  logic                  rd_ack_d;
  logic                  rd_err_d;

  assign full         = (data_count == DEPTH_CNT);
  assign empty        = (data_count == '0);
  assign almost_full  = (data_count >= AF_CNT);
  assign almost_empty = (data_count <= AE_CNT);
  assign state        = state_q;

  fifo_param_ns u_ns (
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .state      (state_q),
    .full       (full),
    .empty      (empty),
    .next_state (next_state),
    .do_wr      (do_wr),
    .do_rd      (do_rd),
    .wr_ack     (wr_ack_d),
    .wr_err     (wr_err_d),
    .rd_ack     (rd_ack_d),
    .rd_err     (rd_err_d)
  );

  // Storage is deliberately left out of reset; the pointers and count
  // alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= d_in;
    end
  end

  // Control registers. Pointers wrap by natural overflow since DEPTH is a
  // power of two. When full with a simultaneous read and write, rd_ptr and
  // wr_ptr alias: the non-blocking read returns the old word while the new
  // one lands in the same slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= INIT;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      data_count <= '0;
      d_out      <= '0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      state_q <= next_state;
      wr_ack  <= wr_ack_d;
      wr_err  <= wr_err_d;
      rd_ack  <= rd_ack_d;
      rd_err  <= rd_err_d;

      if (do_wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end

      if (do_rd) begin
        d_out  <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      unique case ({do_wr, do_rd})
        2'b10:   data_count <= data_count + CNT_W'(1);
        2'b01:   data_count <= data_count - CNT_W'(1);
        default: data_count <= data_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param
// Self-checking bench for fifo_param (DATA_WIDTH=32, DEPTH=8).
// A behavioural model tracks occupancy, expected state and handshakes;
// accepted writes are queued and popped as the expected d_out on reads.
module tb_fifo_param;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  localparam logic [2:0] S_INIT     = 3'b000;
  localparam logic [2:0] S_WRITE    = 3'b001;
  localparam logic [2:0] S_READ     = 3'b010;
  localparam logic [2:0] S_RDWR     = 3'b011;
  localparam logic [2:0] S_WR_ERROR = 3'b101;
  localparam logic [2:0] S_RD_ERROR = 3'b110;
  localparam logic [2:0] S_NO_OP    = 3'b111;

  logic          clk;
  logic          reset_n;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] d_in;
  logic [DW-1:0] d_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic          wr_ack;
  logic          wr_err;
  logic          rd_ack;
  logic          rd_err;
  logic [3:0]    data_count;
  logic [2:0]    state;

  int tests;
  int failures;

  logic [DW-1:0] sb[$];
  int            m_count;
  logic [2:0]    exp_state;
  logic [DW-1:0] exp_dout;
  logic          exp_wr_ack;
  logic          exp_wr_err;
  logic          exp_rd_ack;
  logic          exp_rd_err;

  fifo_param #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_LEVEL   (DEPTH - 2),
    .AE_LEVEL   (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .d_in         (d_in),
    .d_out        (d_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .wr_ack       (wr_ack),
    .wr_err       (wr_err),
    .rd_ack       (rd_ack),
    .rd_err       (rd_err),
    .data_count   (data_count),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clears the model to its post-reset contents.
  task automatic model_reset();
    sb.delete();
    m_count    = 0;
    exp_state  = S_INIT;
    exp_dout   = '0;
    exp_wr_ack = 1'b0;
    exp_wr_err = 1'b0;
    exp_rd_ack = 1'b0;
    exp_rd_err = 1'b0;
  endtask

  // Drives one cycle on the falling edge, predicts its effect, and returns
  // 1 time unit after the following rising edge.
  task automatic step(input logic wr, input logic rd, input logic [DW-1:0] data);
    logic w;
    logic r;
    w = (wr === 1'b1);
    r = (rd === 1'b1);
    @(negedge clk);
    wr_en = wr;
    rd_en = rd;
    d_in  = data;
    exp_wr_ack = 1'b0;
    exp_wr_err = 1'b0;
    exp_rd_ack = 1'b0;
    exp_rd_err = 1'b0;
    if (!w && !r) begin
      exp_state = (exp_state == S_INIT) ? S_INIT : S_NO_OP;
    end else if (w && !r) begin
      if (m_count == DEPTH) begin
        exp_state  = S_WR_ERROR;
        exp_wr_err = 1'b1;
      end else begin
        exp_state  = S_WRITE;
        exp_wr_ack = 1'b1;
        sb.push_back(data);
        m_count++;
      end
    end else if (!w && r) begin
      if (m_count == 0) begin
        exp_state  = S_RD_ERROR;
        exp_rd_err = 1'b1;
      end else begin
        exp_state  = S_READ;
        exp_rd_ack = 1'b1;
        exp_dout   = sb.pop_front();
        m_count--;
      end
    end else begin
      if (m_count == 0) begin
        exp_state  = S_WRITE;
        exp_wr_ack = 1'b1;
        exp_rd_err = 1'b1;
        sb.push_back(data);
        m_count++;
      end else begin
        exp_state  = S_RDWR;
        exp_wr_ack = 1'b1;
        exp_rd_ack = 1'b1;
        exp_dout   = sb.pop_front();
        sb.push_back(data);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    d_in    = '0;
    model_reset();
    #12;
    tests++;
    if ({state, data_count, empty, full, almost_empty, almost_full} !== {S_INIT, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("[TB] FAIL reset_flags: state=%b count=%0d e=%b f=%b ae=%b af=%b", state, data_count, empty, full, almost_empty, almost_full);
    end
    tests++;
    if ({d_out, wr_ack, wr_err, rd_ack, rd_err} !== {32'h0, 4'b0000}) begin
      failures++;
      $display("[TB] FAIL reset_outputs: d_out=%h acks/errs=%b%b%b%b expected 0", d_out, wr_ack, wr_err, rd_ack, rd_err);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b0, '0);
    tests++;
    if (state !== S_INIT) begin
      failures++;
      $display("[TB] FAIL reset_idle_init: got %b expected %b", state, S_INIT);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, DW'(32'h11 * (i + 1)));
      tests++;
      if ({wr_ack, state} !== {1'b1, S_WRITE} || int'(data_count) !== m_count) begin
        failures++;
        $display("[TB] FAIL fill_write[%0d]: ack=%b state=%b count=%0d expected 1/%b/%0d", i, wr_ack, state, data_count, S_WRITE, m_count);
      end
      tests++;
      if (almost_full !== (m_count >= DEPTH - 2)) begin
        failures++;
        $display("[TB] FAIL fill_almost_full[%0d]: got %b at count %0d", i, almost_full, m_count);
      end
    end
    tests++;
    if (full !== 1'b1) begin
      failures++;
      $display("[TB] FAIL fill_full: got %b expected 1", full);
    end
    step(1'b1, 1'b0, 32'h99);
    tests++;
    if ({wr_err, wr_ack, state, data_count} !== {1'b1, 1'b0, S_WR_ERROR, 4'd8}) begin
      failures++;
      $display("[TB] FAIL overflow: err=%b ack=%b state=%b count=%0d expected 1/0/%b/8", wr_err, wr_ack, state, data_count, S_WR_ERROR);
    end
  endtask

  task automatic test_drain_underflow();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, '0);
      tests++;
      if (d_out !== exp_dout || d_out !== DW'(32'h11 * (i + 1))) begin
        failures++;
        $display("[TB] FAIL drain_data[%0d]: got %h expected %h", i, d_out, exp_dout);
      end
      tests++;
      if ({rd_ack, state} !== {1'b1, S_READ} || almost_empty !== (m_count <= 2)) begin
        failures++;
        $display("[TB] FAIL drain_flags[%0d]: ack=%b state=%b ae=%b count=%0d", i, rd_ack, state, almost_empty, m_count);
      end
    end
    tests++;
    if (empty !== 1'b1) begin
      failures++;
      $display("[TB] FAIL drain_empty: got %b expected 1", empty);
    end
    step(1'b0, 1'b1, '0);
    tests++;
    if ({rd_err, rd_ack, state, data_count} !== {1'b1, 1'b0, S_RD_ERROR, 4'd0} || d_out !== 32'h88) begin
      failures++;
      $display("[TB] FAIL underflow: err=%b ack=%b state=%b d_out=%h expected 1/0/%b/88", rd_err, rd_ack, state, d_out, S_RD_ERROR);
    end
  endtask

  task automatic test_idle();
    step(1'b1, 1'b0, 32'hA5A5_0001);
    step(1'b0, 1'b0, '0);
    tests++;
    if ({state, wr_ack, wr_err, rd_ack, rd_err} !== {S_NO_OP, 4'b0000} || int'(data_count) !== m_count) begin
      failures++;
      $display("[TB] FAIL idle_noop: state=%b acks=%b%b%b%b count=%0d expected %b/0000/%0d", state, wr_ack, wr_err, rd_ack, rd_err, data_count, S_NO_OP, m_count);
    end
    step(1'bx, 1'bz, 32'hDEAD_BEEF);
    tests++;
    if ({state, wr_ack, rd_ack} !== {S_NO_OP, 2'b00} || int'(data_count) !== m_count) begin
      failures++;
      $display("[TB] FAIL idle_xz_enables: state=%b acks=%b%b count=%0d expected %b/00/%0d", state, wr_ack, rd_ack, data_count, S_NO_OP, m_count);
    end
  endtask

  task automatic test_simultaneous();
    while (m_count < 4) step(1'b1, 1'b0, 32'hC000_0000 + DW'(m_count));
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 32'hB000_0000 + DW'(i));
      tests++;
      if ({state, wr_ack, rd_ack, data_count} !== {S_RDWR, 2'b11, 4'd4} || d_out !== exp_dout) begin
        failures++;
        $display("[TB] FAIL rdwr[%0d]: state=%b acks=%b%b count=%0d d_out=%h expected %b/11/4/%h", i, state, wr_ack, rd_ack, data_count, d_out, S_RDWR, exp_dout);
      end
    end
    while (m_count > 0) begin
      step(1'b0, 1'b1, '0);
      tests++;
      if (d_out !== exp_dout) begin
        failures++;
        $display("[TB] FAIL rdwr_order: got %h expected %h", d_out, exp_dout);
      end
    end
  endtask

  task automatic test_full_rdwr();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 32'hF000_0000 + DW'(i));
    step(1'b1, 1'b1, 32'hF0F0_F0F0);
    tests++;
    if ({wr_ack, rd_ack, data_count, full} !== {2'b11, 4'd8, 1'b1} || d_out !== 32'hF000_0000) begin
      failures++;
      $display("[TB] FAIL full_rdwr: acks=%b%b count=%0d full=%b d_out=%h expected 11/8/1/f0000000", wr_ack, rd_ack, data_count, full, d_out);
    end
    while (m_count > 0) begin
      step(1'b0, 1'b1, '0);
      tests++;
      if (d_out !== exp_dout) begin
        failures++;
        $display("[TB] FAIL full_rdwr_drain: got %h expected %h", d_out, exp_dout);
      end
    end
  endtask

  task automatic test_empty_rdwr();
    step(1'b1, 1'b1, 32'h1234_5678);
    tests++;
    if ({wr_ack, rd_err, rd_ack, data_count, state} !== {1'b1, 1'b1, 1'b0, 4'd1, S_WRITE} || d_out !== exp_dout) begin
      failures++;
      $display("[TB] FAIL empty_rdwr: wack=%b rerr=%b rack=%b count=%0d state=%b d_out=%h expected 1/1/0/1/%b/%h", wr_ack, rd_err, rd_ack, data_count, state, d_out, S_WRITE, exp_dout);
    end
    step(1'b0, 1'b1, '0);
    tests++;
    if (d_out !== 32'h1234_5678) begin
      failures++;
      $display("[TB] FAIL empty_rdwr_read: got %h expected 12345678", d_out);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'($urandom));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, DW'($urandom));
      step(1'b0, 1'b1, '0);
      tests++;
      if (d_out !== exp_dout || int'(data_count) !== m_count) begin
        failures++;
        $display("[TB] FAIL wrap[%0d]: d_out=%h count=%0d expected %h/%0d", i, d_out, data_count, exp_dout, m_count);
      end
    end
    while (m_count > 0) begin
      step(1'b0, 1'b1, '0);
      tests++;
      if (d_out !== exp_dout) begin
        failures++;
        $display("[TB] FAIL wrap_drain: got %h expected %h", d_out, exp_dout);
      end
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h5000_0000 + DW'(i));
    tests++;
    if (data_count !== 4'd5) begin
      failures++;
      $display("[TB] FAIL midreset_pre: count=%0d expected 5", data_count);
    end
    #2;
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    model_reset();
    #1;
    tests++;
    if ({data_count, empty, state, almost_empty} !== {4'd0, 1'b1, S_INIT, 1'b1} || d_out !== 32'h0) begin
      failures++;
      $display("[TB] FAIL midreset: count=%0d empty=%b state=%b d_out=%h expected 0/1/%b/0", data_count, empty, state, d_out, S_INIT);
    end
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b0, '0);
    tests++;
    if ({state, data_count} !== {S_INIT, 4'd0}) begin
      failures++;
      $display("[TB] FAIL midreset_release: state=%b count=%0d expected %b/0", state, data_count, S_INIT);
    end
    step(1'b0, 1'b1, '0);
    tests++;
    if ({rd_err, state} !== {1'b1, S_RD_ERROR}) begin
      failures++;
      $display("[TB] FAIL midreset_discard: rd_err=%b state=%b expected 1/%b", rd_err, state, S_RD_ERROR);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tests    = 0;
    failures = 0;
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_idle();
    test_simultaneous();
    test_full_rdwr();
    test_empty_rdwr();
    test_wrap();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
